// File: rtl/periph_rx_arbiter.sv
// periph_rx_arbiter
//   Round-robin arbiter that moves packets from NUM_PERIPHS peripheral RX
//   FIFOs toward a single USB TX stream. A granted peripheral may send up to
//   MAX_BURST packets back to back before the grant moves on.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset (0 = reset)
//   fifo_data      per-peripheral read data, peripheral i at [i*PW +: PW];
//                  valid the cycle after the matching fifo_read strobe
//   fifo_empty     per-peripheral empty flags
//   fifo_read      per-peripheral read strobes (zero or one-hot)
//   periph_enable  per-peripheral arbitration enables
//   out_data       {address, payload}, address in the MSBs
//   out_valid      out_data holds a packet
//   out_ready      downstream accepts out_data this cycle
//   idle           1 while no transfer is in progress
//   state_o        current FSM state, for debug and checkers
//
// Handshake: a packet transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid rises, out_data and out_valid stay
// stable until that transfer; out_valid is never withdrawn early.
module periph_rx_arbiter #(
  parameter int NUM_PERIPHS       = 8,
  parameter int USB_PACKET_WIDTH  = 32,
  parameter int PERIPH_ADDR_WIDTH = 3,
  parameter int MAX_BURST         = 4
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic [NUM_PERIPHS*(USB_PACKET_WIDTH-PERIPH_ADDR_WIDTH)-1:0] fifo_data,
  input  logic [NUM_PERIPHS-1:0]                                    fifo_empty,
  output logic [NUM_PERIPHS-1:0]                                    fifo_read,
  input  logic [NUM_PERIPHS-1:0]                                    periph_enable,
  output logic [USB_PACKET_WIDTH-1:0]                               out_data,
  output logic                                                      out_valid,
  input  logic                                                      out_ready,
  output logic                                                      idle,
  output logic [1:0]                                                state_o
);

  localparam int AW = PERIPH_ADDR_WIDTH;
  localparam int PW = USB_PACKET_WIDTH - PERIPH_ADDR_WIDTH;
  localparam int CW = 5;  // holds 0..MAX_BURST for MAX_BURST up to 16

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LATCH  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [AW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]               grant_q, grant_d;
  logic [CW-1:0]               burst_q, burst_d;
  logic [USB_PACKET_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;

  logic [NUM_PERIPHS-1:0]      eligible;
  logic [NUM_PERIPHS-1:0]      read_d;
  logic                        found;
  logic [AW-1:0]               rr_pick;
  logic [AW:0]                 cand;
  logic [PW-1:0]               sel_data;
  logic [AW-1:0]               grant_next;
  logic [CW-1:0]               burst_inc;

  assign eligible = periph_enable & ~fifo_empty;

  // First eligible index at or above rr_ptr, wrapping past NUM_PERIPHS-1.
  // cand is one bit wider so rr_ptr + k cannot overflow before the wrap.
  always_comb begin
    found   = 1'b0;
    rr_pick = '0;
    cand    = '0;
    for (int k = 0; k < NUM_PERIPHS; k++) begin
      cand = {1'b0, rr_ptr_q} + (AW+1)'(k);
      if (cand >= (AW+1)'(NUM_PERIPHS)) begin
        cand = cand - (AW+1)'(NUM_PERIPHS);
      end
      if (!found && eligible[cand[AW-1:0]]) begin
        found   = 1'b1;
        rr_pick = cand[AW-1:0];
      end
    end
  end

  assign sel_data   = fifo_data[int'(grant_q)*PW +: PW];
  assign grant_next = (grant_q == AW'(NUM_PERIPHS-1)) ? '0 : grant_q + AW'(1);
  assign burst_inc  = burst_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_d     = burst_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    read_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          read_d[rr_pick] = 1'b1;
          grant_d         = rr_pick;
          burst_d         = '0;
          state_d         = S_LATCH;
        end
      end
      S_LATCH: begin
        // FIFO word requested last cycle is on fifo_data now.
        out_data_d  = {grant_q, sel_data};
        out_valid_d = 1'b1;
        state_d     = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) begin
          burst_d     = burst_inc;
          out_valid_d = 1'b0;
          if ((burst_inc < CW'(MAX_BURST)) && eligible[grant_q]) begin
            read_d[grant_q] = 1'b1;
            state_d         = S_LATCH;
          end else begin
            rr_ptr_d = grant_next;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_q     <= burst_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // The strobe is combinational from IDLE; gating with rst keeps it low
  // while reset is held even though eligible FIFOs exist.
  assign fifo_read = rst ? read_d : '0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign idle      = (state_q == S_IDLE);
  assign state_o   = state_q;

endmodule
